// File: rtl/eth_rx_pkt_gate_pkg.sv
// rtl/eth_rx_pkt_gate_pkg.sv - shared constants and types for the RX packet gate
package eth_rx_pkt_gate_pkg;

  localparam int DATA_W          = 64;
  localparam int TUSER_W         = 4;
  localparam int WORD_W          = DATA_W + TUSER_W + 1;
  localparam int TUSER_ERR_BIT   = 3;
  localparam int TUSER_BYTES_MSB = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } gate_state_e;

endpackage

// File: rtl/eth_rx_pkt_gate_if.sv
// rtl/eth_rx_pkt_gate_if.sv - MAC-side stream bundle used on both sides of the gate
interface eth_rx_pkt_gate_if;
  import eth_rx_pkt_gate_pkg::*;

  logic [DATA_W-1:0]  tdata;
  logic [TUSER_W-1:0] tuser;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/eth_rx_pkt_gate_ram.sv
// rtl/eth_rx_pkt_gate_ram.sv - simple dual-port frame buffer with registered read port
module eth_rx_pkt_gate_ram #(
  parameter int AW = 11,
  parameter int DW = 69
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_rx_pkt_gate.sv
// rtl/eth_rx_pkt_gate.sv - store-and-forward gate dropping errored, oversized and runt frames
module eth_rx_pkt_gate
  import eth_rx_pkt_gate_pkg::*;
#(
  parameter int SIZE      = 11,
  parameter int MIN_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_rx_pkt_gate_if.slave    s_mac,
  eth_rx_pkt_gate_if.master   m_mac,
  output logic [CNT_W-1:0]    drop_err_cnt,
  output logic [CNT_W-1:0]    drop_ovf_cnt,
  output logic [CNT_W-1:0]    drop_runt_cnt
);

  localparam int PW    = SIZE + 1;
  localparam int DEPTH = 1 << SIZE;
  localparam int WC_W  = $clog2(MIN_WORDS + 1);
  localparam logic [WC_W-1:0]    MIN_WC   = WC_W'(MIN_WORDS);
  localparam logic [TUSER_W-1:0] ERR_MASK = ~(TUSER_W'(1) << TUSER_ERR_BIT);

  gate_state_e       state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_cmt_q, wr_cmt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]  runt_cnt_q, runt_cnt_d;
  logic              tready_q, tready_d;
  logic              r_vld_q, r_vld_d;
  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;

  logic              beat, full, ram_we, ram_re, out_load;
  logic              eof, inc_err, inc_ovf, inc_runt;
  logic [WC_W-1:0]   wcnt_eof;
  logic [WORD_W-1:0] ram_rdata;

  assign beat = s_mac.tvalid && tready_q;
  // Uncommitted words count as occupied so a growing frame cannot overrun unread data.
  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

  eth_rx_pkt_gate_ram #(.AW(SIZE), .DW(WORD_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[SIZE-1:0]),
    .wdata ({s_mac.tlast, s_mac.tuser, s_mac.tdata}),
    .re    (ram_re),
    .raddr (rd_ptr_q[SIZE-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    wcnt_d   = wcnt_q;
    ram_we   = 1'b0;
    eof      = 1'b0;
    wcnt_eof = '0;
    inc_err  = 1'b0;
    inc_ovf  = 1'b0;
    inc_runt = 1'b0;
    tready_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (beat) begin
          if (full) begin
            inc_ovf = 1'b1;
            state_d = s_mac.tlast ? IDLE : DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = WC_W'(1);
            state_d  = WRITE;
            eof      = s_mac.tlast;
            wcnt_eof = WC_W'(1);
          end
        end
      end
      WRITE: begin
        if (beat) begin
          if (full) begin
            wr_ptr_d = wr_cmt_q;
            inc_ovf  = 1'b1;
            state_d  = s_mac.tlast ? IDLE : DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            wcnt_d   = (wcnt_q >= MIN_WC) ? wcnt_q : wcnt_q + WC_W'(1);
            eof      = s_mac.tlast;
            wcnt_eof = wcnt_d;
          end
        end
      end
      DROP: begin
        if (beat && s_mac.tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eof) begin
      state_d = IDLE;
      if (s_mac.tuser[TUSER_ERR_BIT]) begin
        wr_ptr_d = wr_cmt_q;
        inc_err  = 1'b1;
      end else if (wcnt_eof < MIN_WC) begin
        wr_ptr_d = wr_cmt_q;
        inc_runt = 1'b1;
      end else begin
        wr_cmt_d = wr_ptr_q + PW'(1);
      end
    end

    err_cnt_d  = (inc_err  && !(&err_cnt_q))  ? err_cnt_q  + CNT_W'(1) : err_cnt_q;
    ovf_cnt_d  = (inc_ovf  && !(&ovf_cnt_q))  ? ovf_cnt_q  + CNT_W'(1) : ovf_cnt_q;
    runt_cnt_d = (inc_runt && !(&runt_cnt_q)) ? runt_cnt_q + CNT_W'(1) : runt_cnt_q;
  end

  // Two-stage prefetch: RAM read register feeds the output register, each refilled as soon as it drains.
  always_comb begin
    out_load   = r_vld_q && (!out_vld_q || m_mac.tready);
    ram_re     = (rd_ptr_q != wr_cmt_q) && (!r_vld_q || out_load);
    rd_ptr_d   = ram_re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    r_vld_d    = ram_re || (r_vld_q && !out_load);
    out_vld_d  = out_load || (out_vld_q && !m_mac.tready);
    out_word_d = out_load ? ram_rdata : out_word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      wcnt_q     <= '0;
      err_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
      runt_cnt_q <= '0;
      tready_q   <= 1'b0;
      r_vld_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_ptr_q   <= rd_ptr_d;
      wcnt_q     <= wcnt_d;
      err_cnt_q  <= err_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      runt_cnt_q <= runt_cnt_d;
      tready_q   <= tready_d;
      r_vld_q    <= r_vld_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
    end
  end

  assign s_mac.tready  = tready_q;
  assign m_mac.tvalid  = out_vld_q;
  assign m_mac.tdata   = out_word_q[DATA_W-1:0];
  assign m_mac.tuser   = out_word_q[DATA_W +: TUSER_W] & ERR_MASK;
  assign m_mac.tlast   = out_word_q[WORD_W-1];
  assign drop_err_cnt  = err_cnt_q;
  assign drop_ovf_cnt  = ovf_cnt_q;
  assign drop_runt_cnt = runt_cnt_q;

endmodule

// File: tb/tb_eth_rx_pkt_gate.sv
// tb/tb_eth_rx_pkt_gate.sv - scoreboard bench for the RX packet gate
module tb_eth_rx_pkt_gate;

  localparam int SIZE      = 5;
  localparam int MIN_WORDS = 2;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  u;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] drop_err_cnt, drop_ovf_cnt, drop_runt_cnt;

  eth_rx_pkt_gate_if s_if ();
  eth_rx_pkt_gate_if m_if ();

  eth_rx_pkt_gate #(.SIZE(SIZE), .MIN_WORDS(MIN_WORDS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_mac         (s_if),
    .m_mac         (m_if),
    .drop_err_cnt  (drop_err_cnt),
    .drop_ovf_cnt  (drop_ovf_cnt),
    .drop_runt_cnt (drop_runt_cnt)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int tready_low = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_cnts(input string name, input int e_err, input int e_ovf, input int e_runt);
    chk({name, "_err"},  64'(drop_err_cnt),  64'(e_err));
    chk({name, "_ovf"},  64'(drop_ovf_cnt),  64'(e_ovf));
    chk({name, "_runt"}, 64'(drop_runt_cnt), 64'(e_runt));
  endtask

  task automatic drive_beat(input int fid, input int i, input int n, input logic [3:0] last_user, input bit ok);
    logic [31:0] rnd;
    beat_t b;
    rnd = $urandom();
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'(fid), 16'(i), rnd};
    s_if.tuser  = (i == n - 1) ? last_user : 4'h0;
    s_if.tlast  = (i == n - 1);
    if (s_if.tready !== 1'b1) tready_low++;
    if (ok) begin
      b.d = s_if.tdata;
      b.u = s_if.tuser & 4'h7;
      b.l = s_if.tlast;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame(input int fid, input int n, input logic [3:0] last_user, input bit ok);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_beat(fid, i, n, last_user, ok);
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_space(input int th);
    int k;
    k = 0;
    while (exp_q.size() > th && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > th) begin
      errors++;
      $display("FAIL wait_space timeout pending=%0d required<=%0d", exp_q.size(), th);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: choose ready for the coming edge, then compare the beat that edge will consume.
  initial begin
    beat_t e;
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
      #1;
      if (rst_n && m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got data=%h user=%h last=%b expected none",
                   m_if.tdata, m_if.tuser, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_if.tdata, m_if.tuser, m_if.tlast} !== e) begin
            errors++;
            $display("FAIL beat got %h/%h/%b expected %h/%h/%b",
                     m_if.tdata, m_if.tuser, m_if.tlast, e.d, e.u, e.l);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [3:0] lu;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk_cnts("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_if.tready), 64'd1);

    // Good frame and commit-to-output latency
    ready_mode = 0;
    send_frame(1, 8, 4'h4, 1'b1);
    @(negedge clk);
    chk("lat_edge1_tvalid", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    chk("lat_edge2_tvalid", 64'(m_if.tvalid), 64'd1);
    wait_drain("good");
    chk_cnts("good", 0, 0, 0);

    // Errored frame is rolled back, following frame passes
    send_frame(2, 6, 4'h8, 1'b0);
    send_frame(3, 4, 4'h2, 1'b1);
    wait_drain("err");
    chk_cnts("err", 1, 0, 0);

    // Runt then minimum-length frame
    send_frame(4, 1, 4'h0, 1'b0);
    send_frame(5, 2, 4'h0, 1'b1);
    wait_drain("runt");
    chk_cnts("runt", 1, 0, 1);

    // Overflow with output stalled; input never back-pressured
    ready_mode = 2;
    tready_low = 0;
    send_frame(6, 40, 4'h0, 1'b0);
    chk("ovf_s_tready_low_beats", 64'(tready_low), 64'd0);
    chk_cnts("ovf", 1, 1, 1);
    repeat (3) @(negedge clk);
    chk("ovf_no_tvalid", 64'(m_if.tvalid), 64'd0);
    ready_mode = 0;
    repeat (10) @(negedge clk);
    send_frame(7, 10, 4'h3, 1'b1);
    wait_drain("ovf_next");

    // Random backpressure, pointer wrap; pacing keeps each frame within buffer space
    ready_mode = 1;
    for (int f = 0; f < 30; f++) begin
      wait_space((1 << SIZE) - 17);
      n  = $urandom_range(3, 17);
      lu = 4'($urandom_range(0, 7));
      send_frame(100 + f, n, lu, 1'b1);
    end
    wait_drain("rand");
    ready_mode = 0;
    chk_cnts("rand", 1, 1, 1);

    // Reset in the middle of a frame while output holds a stalled beat
    ready_mode = 2;
    send_frame(8, 3, 4'h0, 1'b1);
    k = 0;
    while (m_if.tvalid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_pre_tvalid", 64'(m_if.tvalid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_beat(9, i, 8, 4'h0, 1'b0);
    end
    @(negedge clk);
    drive_beat(9, 2, 8, 4'h0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    chk_cnts("mid_rst", 0, 0, 0);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    send_frame(10, 5, 4'h5, 1'b1);
    wait_drain("post_rst");
    chk_cnts("post_rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
